// File: rtl/gp_dma_xfer_pkg.sv
// Shared definitions for the general-purpose DMA burst sequencer:
// channel count, FSM encoding, byte stride and the burst-length clip helper.
package gp_dma_xfer_pkg;

    localparam int GP_DMA_NCH    = 4;
    localparam int GP_DMA_STRIDE = 4;

    typedef logic [1:0] ch_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    // Beats for one tenure: the smaller of the remaining count and the burst limit.
    function automatic logic [4:0] clip_beats(input logic [31:0] rem, input logic [31:0] lim);
        if (rem < lim) begin
            return rem[4:0];
        end else begin
            return lim[4:0];
        end
    endfunction

endpackage

// File: rtl/gp_dma_ch_ctx.sv
// Per-channel context: current beat address and remaining word count,
// with abort > load > decrement priority.
module gp_dma_ch_ctx
    import gp_dma_xfer_pkg::*;
#(
    parameter int AW = 32,
    parameter int LW = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic [AW-1:0] i_addr,
    input  logic [LW-1:0] i_len,
    input  logic          i_dec,
    output logic [AW-1:0] o_addr,
    output logic [LW-1:0] o_rem,
    output logic          o_pending
);

    logic [AW-1:0] r_addr;
    logic [LW-1:0] r_rem;

    // A load is accepted only into an idle channel; an aborted beat still
    // advances the address but never drives the count below zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr <= '0;
            r_rem  <= '0;
        end else if (i_abort) begin
            r_rem  <= '0;
        end else if (i_start && (r_rem == '0) && (i_len != '0)) begin
            r_addr <= i_addr;
            r_rem  <= i_len;
        end else if (i_dec) begin
            r_addr <= r_addr + AW'(GP_DMA_STRIDE);
            if (r_rem != '0) begin
                r_rem <= r_rem - LW'(1);
            end
        end
    end

    assign o_addr    = r_addr;
    assign o_rem     = r_rem;
    assign o_pending = (r_rem != '0);

endmodule

// File: rtl/gp_dma_xfer.sv
// Burst sequencer: requests an arbiter decision, then issues one burst of
// word commands for the granted channel on the cbus master port.
module gp_dma_xfer
    import gp_dma_xfer_pkg::*;
#(
    parameter int BURST_LEN = 8,
    parameter int AW        = 32,
    parameter int LW        = 16
) (
    input  logic                     cbus_clk,
    input  logic                     cbus_rst,
    input  logic [GP_DMA_NCH-1:0]    ch_start,
    input  logic [GP_DMA_NCH*AW-1:0] ch_addr,
    input  logic [GP_DMA_NCH*LW-1:0] ch_len,
    input  logic [GP_DMA_NCH-1:0]    ch_abort,
    output logic [GP_DMA_NCH-1:0]    dma_pending,
    output logic                     cycle_start,
    input  logic [1:0]               owner,
    output logic                     active,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [AW-1:0]            m_addr,
    output logic [1:0]               m_ch,
    output logic                     m_last,
    output logic [GP_DMA_NCH-1:0]    ch_done
);

    state_t                r_state;
    ch_idx_t               r_cur;
    logic [4:0]            r_beats;
    logic                  r_abort_seen;
    logic                  r_cycle_start;
    logic                  r_active;
    logic                  r_m_valid;
    logic [AW-1:0]         r_m_addr;
    logic                  r_m_last;
    logic [GP_DMA_NCH-1:0] r_ch_done;

    logic [AW-1:0]         w_addr [GP_DMA_NCH];
    logic [LW-1:0]         w_rem  [GP_DMA_NCH];
    logic [GP_DMA_NCH-1:0] w_pending;
    logic [GP_DMA_NCH-1:0] w_dec;
    logic                  w_accept;
    logic [4:0]            w_beats_n;

    assign w_accept  = r_m_valid && m_ready;
    assign w_beats_n = clip_beats(32'(w_rem[owner]), 32'(BURST_LEN));

    for (genvar g = 0; g < GP_DMA_NCH; g++) begin : g_ctx
        assign w_dec[g] = w_accept && (r_cur == ch_idx_t'(g));

        gp_dma_ch_ctx #(.AW(AW), .LW(LW)) u_ctx (
            .i_clk     (cbus_clk),
            .i_rst     (cbus_rst),
            .i_start   (ch_start[g]),
            .i_abort   (ch_abort[g]),
            .i_addr    (ch_addr[g*AW +: AW]),
            .i_len     (ch_len[g*LW +: LW]),
            .i_dec     (w_dec[g]),
            .o_addr    (w_addr[g]),
            .o_rem     (w_rem[g]),
            .o_pending (w_pending[g])
        );
    end

    // Sequencer FSM with all bus-side outputs registered.
    always_ff @(posedge cbus_clk) begin
        if (cbus_rst) begin
            r_state       <= ST_IDLE;
            r_cur         <= '0;
            r_beats       <= '0;
            r_abort_seen  <= 1'b0;
            r_cycle_start <= 1'b0;
            r_active      <= 1'b0;
            r_m_valid     <= 1'b0;
            r_m_addr      <= '0;
            r_m_last      <= 1'b0;
            r_ch_done     <= '0;
        end else begin
            r_cycle_start <= 1'b0;
            r_ch_done     <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pending != '0) begin
                        r_state       <= ST_ARB;
                        r_cycle_start <= 1'b1;
                    end
                end
                ST_ARB: begin
                    // An abort landing on the grant edge leaves an empty tenure.
                    r_state      <= ST_XFER;
                    r_cur        <= owner;
                    r_beats      <= w_beats_n;
                    r_abort_seen <= 1'b0;
                    r_active     <= 1'b1;
                    r_m_addr     <= w_addr[owner];
                    r_m_valid    <= (w_rem[owner] != '0) && !ch_abort[owner];
                    r_m_last     <= (w_beats_n == 5'd1) || (w_rem[owner] == LW'(1));
                end
                ST_XFER: begin
                    if (!r_m_valid) begin
                        r_state  <= ST_IDLE;
                        r_active <= 1'b0;
                        r_m_last <= 1'b0;
                    end else if (m_ready) begin
                        if ((w_rem[r_cur] == LW'(1)) && !ch_abort[r_cur]) begin
                            r_ch_done[r_cur] <= 1'b1;
                        end
                        if (r_m_last || ch_abort[r_cur]) begin
                            r_state   <= ST_IDLE;
                            r_active  <= 1'b0;
                            r_m_valid <= 1'b0;
                            r_m_last  <= 1'b0;
                        end else begin
                            r_m_addr <= r_m_addr + AW'(GP_DMA_STRIDE);
                            r_beats  <= r_beats - 5'd1;
                            r_m_last <= (r_beats == 5'd2) || (w_rem[r_cur] == LW'(2));
                        end
                    end else begin
                        if (ch_abort[r_cur]) begin
                            r_abort_seen <= 1'b1;
                        end
                        r_m_last <= r_m_last || r_abort_seen || ch_abort[r_cur];
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign dma_pending = w_pending;
    assign cycle_start = r_cycle_start;
    assign active      = r_active;
    assign m_valid     = r_m_valid;
    assign m_addr      = r_m_addr;
    assign m_ch        = r_cur;
    assign m_last      = r_m_last;
    assign ch_done     = r_ch_done;

endmodule

// File: tb/tb_gp_dma_xfer.sv
// Directed self-checking bench for gp_dma_xfer; the bench plays the arbiter
// by driving owner to the single channel under test.
module tb_gp_dma_xfer;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   ch_start;
    logic [127:0] ch_addr;
    logic [63:0]  ch_len;
    logic [3:0]   ch_abort;
    logic [3:0]   dma_pending;
    logic         cycle_start;
    logic [1:0]   owner;
    logic         active;
    logic         m_valid;
    logic         m_ready;
    logic [31:0]  m_addr;
    logic [1:0]   m_ch;
    logic         m_last;
    logic [3:0]   ch_done;

    int n_checks = 0;
    int n_errors = 0;

    gp_dma_xfer #(.BURST_LEN(8), .AW(32), .LW(16)) dut (
        .cbus_clk    (clk),
        .cbus_rst    (rst),
        .ch_start    (ch_start),
        .ch_addr     (ch_addr),
        .ch_len      (ch_len),
        .ch_abort    (ch_abort),
        .dma_pending (dma_pending),
        .cycle_start (cycle_start),
        .owner       (owner),
        .active      (active),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_addr      (m_addr),
        .m_ch        (m_ch),
        .m_last      (m_last),
        .ch_done     (ch_done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int ch, input logic [31:0] a, input logic [15:0] l);
        ch_addr[ch*32 +: 32] = a;
        ch_len[ch*16 +: 16]  = l;
        ch_start = 4'b0001 << ch;
        tick;
        ch_start = 4'b0000;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        n_checks++;
        if ({dma_pending, cycle_start, active, m_valid, m_addr, m_ch, m_last, ch_done} !== 45'd0) begin
            n_errors++;
            $display("FAIL reset_outputs got pend=%b cs=%b act=%b v=%b a=%h ch=%0d l=%b done=%b exp all 0",
                     dma_pending, cycle_start, active, m_valid, m_addr, m_ch, m_last, ch_done);
        end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_single;
        logic [31:0] exp_a [3];
        exp_a[0] = 32'h1000; exp_a[1] = 32'h1004; exp_a[2] = 32'h1008;
        owner = 2'd0;
        m_ready = 1'b1;
        load(0, 32'h1000, 16'd3);
        n_checks++;
        if ({dma_pending, m_valid} !== {4'b0001, 1'b0}) begin
            n_errors++;
            $display("FAIL single_pending got pend=%b v=%b exp pend=0001 v=0", dma_pending, m_valid);
        end
        tick;
        n_checks++;
        if ({cycle_start, active, m_valid} !== 3'b100) begin
            n_errors++;
            $display("FAIL single_arb got cs=%b act=%b v=%b exp 1 0 0", cycle_start, active, m_valid);
        end
        for (int i = 0; i < 3; i++) begin
            tick;
            n_checks++;
            if ({m_valid, active, m_addr, m_ch, m_last} !== {1'b1, 1'b1, exp_a[i], 2'd0, (i == 2)}) begin
                n_errors++;
                $display("FAIL single_beat%0d got v=%b act=%b a=%h ch=%0d l=%b exp addr %h last %0d",
                         i, m_valid, active, m_addr, m_ch, m_last, exp_a[i], (i == 2));
            end
        end
        tick;
        n_checks++;
        if ({m_valid, active, ch_done, dma_pending} !== {1'b0, 1'b0, 4'b0001, 4'b0000}) begin
            n_errors++;
            $display("FAIL single_done got v=%b act=%b done=%b pend=%b exp 0 0 0001 0000",
                     m_valid, active, ch_done, dma_pending);
        end
        tick;
    endtask

    task automatic test_burst_split;
        int tlen[$];
        int gaps[$];
        int cs = 0;
        int cur = 0;
        int gap = 0;
        int bad_addr = 0;
        int done = 0;
        bit seen = 1'b0;
        logic [31:0] exp_a = 32'h8000;
        owner = 2'd1;
        m_ready = 1'b1;
        load(1, 32'h8000, 16'd20);
        for (int i = 0; i < 40; i++) begin
            if (cycle_start) cs++;
            if (ch_done[1]) done++;
            if (active) begin
                if (seen && gap > 0) gaps.push_back(gap);
                gap = 0;
            end else begin
                gap++;
            end
            if (m_valid && m_ready) begin
                if (m_addr !== exp_a || m_ch !== 2'd1) bad_addr++;
                exp_a = exp_a + 32'd4;
                cur++;
                if (m_last) begin
                    tlen.push_back(cur);
                    cur = 0;
                    seen = 1'b1;
                end
            end
            tick;
        end
        n_checks++;
        if (tlen.size() != 3 || tlen[0] != 8 || tlen[1] != 8 || tlen[2] != 4) begin
            n_errors++;
            $display("FAIL split_tenures got %0d tenures %p exp 8 8 4", tlen.size(), tlen);
        end
        n_checks++;
        if (cs != 3 || gaps.size() != 2 || gaps[0] != 2 || gaps[1] != 2) begin
            n_errors++;
            $display("FAIL split_arb got cycle_start=%0d gaps=%p exp 3 and gaps 2 2", cs, gaps);
        end
        n_checks++;
        if (bad_addr != 0 || done != 1 || dma_pending !== 4'b0000) begin
            n_errors++;
            $display("FAIL split_addr_done got bad_addr=%0d done=%0d pend=%b exp 0 1 0000",
                     bad_addr, done, dma_pending);
        end
    endtask

    task automatic test_backpressure;
        int bad_hold = 0;
        owner = 2'd0;
        m_ready = 1'b1;
        load(0, 32'h2000, 16'd4);
        tick;
        tick;
        tick;
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (m_valid !== 1'b1 || m_addr !== 32'h2004 || m_ch !== 2'd0 || m_last !== 1'b0 ||
                dut.g_ctx[0].u_ctx.r_rem !== 16'd3) bad_hold++;
        end
        n_checks++;
        if (bad_hold != 0) begin
            n_errors++;
            $display("FAIL bp_hold got %0d unstable cycles exp 0 (a=%h rem=%0d)",
                     bad_hold, m_addr, dut.g_ctx[0].u_ctx.r_rem);
        end
        m_ready = 1'b1;
        tick;
        n_checks++;
        if ({m_valid, m_addr, m_last} !== {1'b1, 32'h2008, 1'b0} || dut.g_ctx[0].u_ctx.r_rem !== 16'd2) begin
            n_errors++;
            $display("FAIL bp_resume got v=%b a=%h l=%b rem=%0d exp 1 2008 0 2",
                     m_valid, m_addr, m_last, dut.g_ctx[0].u_ctx.r_rem);
        end
        tick;
        tick;
        n_checks++;
        if ({m_valid, ch_done, dma_pending} !== {1'b0, 4'b0001, 4'b0000}) begin
            n_errors++;
            $display("FAIL bp_done got v=%b done=%b pend=%b exp 0 0001 0000", m_valid, ch_done, dma_pending);
        end
        tick;
    endtask

    task automatic test_abort;
        owner = 2'd2;
        m_ready = 1'b1;
        load(2, 32'h3000, 16'd6);
        tick;
        tick;
        tick;
        m_ready = 1'b0;
        ch_abort = 4'b0100;
        tick;
        ch_abort = 4'b0000;
        n_checks++;
        if ({m_valid, m_addr, m_ch, m_last, dma_pending[2]} !== {1'b1, 32'h3004, 2'd2, 1'b1, 1'b0}) begin
            n_errors++;
            $display("FAIL abort_hold got v=%b a=%h ch=%0d l=%b pend2=%b exp 1 3004 2 1 0",
                     m_valid, m_addr, m_ch, m_last, dma_pending[2]);
        end
        tick;
        m_ready = 1'b1;
        tick;
        n_checks++;
        if ({m_valid, active, ch_done, dma_pending} !== {1'b0, 1'b0, 4'b0000, 4'b0000}) begin
            n_errors++;
            $display("FAIL abort_end got v=%b act=%b done=%b pend=%b exp 0 0 0000 0000",
                     m_valid, active, ch_done, dma_pending);
        end
        tick;
        n_checks++;
        if ({cycle_start, active, ch_done} !== 6'd0) begin
            n_errors++;
            $display("FAIL abort_idle got cs=%b act=%b done=%b exp 0 0 0000", cycle_start, active, ch_done);
        end
    endtask

    task automatic test_boundary;
        logic [31:0] exp_a [4];
        int bad = 0;
        exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h0; exp_a[3] = 32'h4;
        owner = 2'd3;
        m_ready = 1'b1;
        load(3, 32'hFFFF_FFF8, 16'd4);
        tick;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (m_valid !== 1'b1 || m_addr !== exp_a[i] || m_ch !== 2'd3 || m_last !== (i == 3)) begin
                bad++;
                $display("FAIL wrap_beat%0d got a=%h l=%b exp %h", i, m_addr, m_last, exp_a[i]);
            end
        end
        n_checks++;
        if (bad != 0) n_errors++;
        tick;
        n_checks++;
        if ({ch_done, dma_pending} !== {4'b1000, 4'b0000}) begin
            n_errors++;
            $display("FAIL wrap_done got done=%b pend=%b exp 1000 0000", ch_done, dma_pending);
        end
        tick;
        ch_addr[31:0] = 32'h5000;
        ch_len[15:0]  = 16'd7;
        ch_start = 4'b0001;
        ch_abort = 4'b0001;
        tick;
        ch_start = 4'b0000;
        ch_abort = 4'b0000;
        tick;
        n_checks++;
        if ({dma_pending, cycle_start} !== 5'd0) begin
            n_errors++;
            $display("FAIL start_abort got pend=%b cs=%b exp 0000 0", dma_pending, cycle_start);
        end
        load(1, 32'h6000, 16'd0);
        tick;
        n_checks++;
        if ({dma_pending, cycle_start} !== 5'd0) begin
            n_errors++;
            $display("FAIL len_zero got pend=%b cs=%b exp 0000 0", dma_pending, cycle_start);
        end
    endtask

    task automatic test_reset_mid;
        owner = 2'd0;
        m_ready = 1'b1;
        load(0, 32'h4000, 16'd5);
        tick;
        tick;
        tick;
        n_checks++;
        if ({m_valid, m_addr} !== {1'b1, 32'h4004}) begin
            n_errors++;
            $display("FAIL rstmid_setup got v=%b a=%h exp 1 4004", m_valid, m_addr);
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n_checks++;
        if ({dma_pending, cycle_start, active, m_valid, m_addr, m_ch, m_last, ch_done} !== 45'd0) begin
            n_errors++;
            $display("FAIL rstmid_outputs got pend=%b act=%b v=%b a=%h l=%b exp all 0",
                     dma_pending, active, m_valid, m_addr, m_last);
        end
        tick;
        n_checks++;
        if ({dma_pending, cycle_start, m_valid} !== 6'd0) begin
            n_errors++;
            $display("FAIL rstmid_after got pend=%b cs=%b v=%b exp 0", dma_pending, cycle_start, m_valid);
        end
    endtask

    initial begin
        rst = 1'b1;
        ch_start = 4'b0;
        ch_abort = 4'b0;
        ch_addr = '0;
        ch_len = '0;
        owner = 2'd0;
        m_ready = 1'b1;
        test_reset;
        test_single;
        test_burst_split;
        test_backpressure;
        test_abort;
        test_boundary;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
